// File: rtl/sr_ff_bank_if.sv
// sr_ff_bank_if: control / data bundle for the sr_ff_bank storage cells.
// master drives mode, enable and per-channel stimulus; slave returns state.
interface sr_ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             EN;
  logic [1:0]       MODE;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] R;
  logic             CLR_ILL;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] QF;
  logic [WIDTH-1:0] ILLEGAL;
  logic [CNT_W-1:0] ILL_CNT;

  modport master (
    output EN, MODE, S, R, CLR_ILL,
    input  Q, QF, ILLEGAL, ILL_CNT
  );

  modport slave (
    input  EN, MODE, S, R, CLR_ILL,
    output Q, QF, ILLEGAL, ILL_CNT
  );
endinterface

// File: rtl/sr_ff_bank.sv
// sr_ff_bank: WIDTH edge-triggered bistable cells with a shared runtime mode
// (SR / JK / D / T), separate true and false outputs, and tracking of the
// forbidden SR pair through sticky per-channel flags and a saturating counter.
// Optional build macro SR_FF_BANK_SYNC_EN inserts 2-flop synchronisers on
// S, R and MODE (latency 3 cycles); undefined, inputs are used directly.
module sr_ff_bank #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input logic          CLK,
  input logic          RST_N,
  sr_ff_bank_if.slave  bus
);

  localparam logic [1:0] MODE_SR = 2'b00;
  localparam logic [1:0] MODE_JK = 2'b01;
  localparam logic [1:0] MODE_D  = 2'b10;
  localparam logic [1:0] MODE_T  = 2'b11;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] s_use;
  logic [WIDTH-1:0] r_use;
  logic [1:0]       mode_use;

`ifdef SR_FF_BANK_SYNC_EN
  logic [WIDTH-1:0] s_meta_r, s_sync_r;
  logic [WIDTH-1:0] r_meta_r, r_sync_r;
  logic [1:0]       mode_meta_r, mode_sync_r;

  // Two-stage synchronisers for the asynchronous stimulus inputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s_meta_r    <= {WIDTH{1'b0}};
      s_sync_r    <= {WIDTH{1'b0}};
      r_meta_r    <= {WIDTH{1'b0}};
      r_sync_r    <= {WIDTH{1'b0}};
      mode_meta_r <= 2'b00;
      mode_sync_r <= 2'b00;
    end else begin
      s_meta_r    <= bus.S;
      s_sync_r    <= s_meta_r;
      r_meta_r    <= bus.R;
      r_sync_r    <= r_meta_r;
      mode_meta_r <= bus.MODE;
      mode_sync_r <= mode_meta_r;
    end
  end

  assign s_use    = s_sync_r;
  assign r_use    = r_sync_r;
  assign mode_use = mode_sync_r;
`else
  assign s_use    = bus.S;
  assign r_use    = bus.R;
  assign mode_use = bus.MODE;
`endif

  logic [WIDTH-1:0] q_r, qf_r, ill_r;
  logic [CNT_W-1:0] cnt_r;
  logic [WIDTH-1:0] q_nxt_s, qf_nxt_s;
  logic [WIDTH-1:0] ill_hit_s;
  logic             ill_event_s;

  // Per-channel next Q/QF for the selected mode; SR may hold or create 0/0.
  always_comb begin
    q_nxt_s  = q_r;
    qf_nxt_s = qf_r;
    for (int i = 0; i < WIDTH; i++) begin
      case (mode_use)
        MODE_SR: begin
          case ({s_use[i], r_use[i]})
            2'b01:   begin q_nxt_s[i] = 1'b0; qf_nxt_s[i] = 1'b1; end
            2'b10:   begin q_nxt_s[i] = 1'b1; qf_nxt_s[i] = 1'b0; end
            2'b11:   begin q_nxt_s[i] = 1'b0; qf_nxt_s[i] = 1'b0; end
            default: begin q_nxt_s[i] = q_r[i]; qf_nxt_s[i] = qf_r[i]; end
          endcase
        end
        MODE_JK: begin
          // QF is rebuilt from the new Q, which also resolves a held 0/0 pair.
          case ({s_use[i], r_use[i]})
            2'b01:   q_nxt_s[i] = 1'b0;
            2'b10:   q_nxt_s[i] = 1'b1;
            2'b11:   q_nxt_s[i] = ~q_r[i];
            default: q_nxt_s[i] = q_r[i];
          endcase
          qf_nxt_s[i] = ~q_nxt_s[i];
        end
        MODE_D: begin
          q_nxt_s[i]  = s_use[i];
          qf_nxt_s[i] = ~s_use[i];
        end
        MODE_T: begin
          q_nxt_s[i]  = q_r[i] ^ s_use[i];
          qf_nxt_s[i] = ~(q_r[i] ^ s_use[i]);
        end
        default: begin
          q_nxt_s[i]  = q_r[i];
          qf_nxt_s[i] = qf_r[i];
        end
      endcase
    end
  end

  // Forbidden-pair detection, only meaningful in SR mode on an enabled edge.
  always_comb begin
    if (mode_use == MODE_SR) begin
      ill_hit_s = s_use & r_use;
    end else begin
      ill_hit_s = {WIDTH{1'b0}};
    end
    ill_event_s = bus.EN & (|ill_hit_s);
  end

  // Cell state: updates only when enabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q_r  <= {WIDTH{1'b0}};
      qf_r <= {WIDTH{1'b1}};
    end else if (bus.EN) begin
      q_r  <= q_nxt_s;
      qf_r <= qf_nxt_s;
    end else begin
      q_r  <= q_r;
      qf_r <= qf_r;
    end
  end

  // Illegal tracking: a fresh event beats a simultaneous clear; clear works even when disabled.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ill_r <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else if (ill_event_s) begin
      if (bus.CLR_ILL) begin
        ill_r <= ill_hit_s;
        cnt_r <= CNT_ONE;
      end else begin
        ill_r <= ill_r | ill_hit_s;
        cnt_r <= (cnt_r == CNT_MAX) ? cnt_r : cnt_r + CNT_ONE;
      end
    end else if (bus.CLR_ILL) begin
      ill_r <= {WIDTH{1'b0}};
      cnt_r <= {CNT_W{1'b0}};
    end else begin
      ill_r <= ill_r;
      cnt_r <= cnt_r;
    end
  end

  assign bus.Q       = q_r;
  assign bus.QF      = qf_r;
  assign bus.ILLEGAL = ill_r;
  assign bus.ILL_CNT = cnt_r;

endmodule

// File: tb/tb_sr_ff_bank.sv
// tb_sr_ff_bank: table-driven bench with a scoreboard queue of expected
// outputs; WIDTH=8, CNT_W=2 so counter saturation is reachable quickly.
module tb_sr_ff_bank;

  localparam int WIDTH = 8;
  localparam int CNT_W = 2;

  typedef struct {
    logic             en;
    logic [1:0]       mode;
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic             clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qf;
    logic [WIDTH-1:0] ill;
    logic [CNT_W-1:0] cnt;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qf;
    logic [WIDTH-1:0] ill;
    logic [CNT_W-1:0] cnt;
    string            name;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;
  exp_t sb[$];
  vec_t vecs[$];

  sr_ff_bank_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  sr_ff_bank #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_exp(input logic [WIDTH-1:0] q, input logic [WIDTH-1:0] qf,
                          input logic [WIDTH-1:0] ill, input logic [CNT_W-1:0] cnt,
                          input string name);
    exp_t e;
    e.q = q; e.qf = qf; e.ill = ill; e.cnt = cnt; e.name = name;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    n_cmp++;
    if (sb.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard_empty: no expected entry for observed output");
    end else begin
      e = sb.pop_front();
      if (bus.Q !== e.q || bus.QF !== e.qf || bus.ILLEGAL !== e.ill || bus.ILL_CNT !== e.cnt) begin
        n_bad++;
        $display("FAIL %s: got Q=%h QF=%h ILL=%h CNT=%0d, want Q=%h QF=%h ILL=%h CNT=%0d",
                 e.name, bus.Q, bus.QF, bus.ILLEGAL, bus.ILL_CNT, e.q, e.qf, e.ill, e.cnt);
      end
    end
  endtask

  task automatic drive(input logic en, input logic [1:0] mode, input logic [WIDTH-1:0] s,
                       input logic [WIDTH-1:0] r, input logic clr);
    bus.EN = en; bus.MODE = mode; bus.S = s; bus.R = r; bus.CLR_ILL = clr;
  endtask

  task automatic apply(input vec_t v, input string name);
    drive(v.en, v.mode, v.s, v.r, v.clr);
    push_exp(v.q, v.qf, v.ill, v.cnt, name);
    @(posedge clk);
    #1;
    pop_check();
  endtask

  task automatic add(input logic en, input logic [1:0] mode, input logic [WIDTH-1:0] s,
                     input logic [WIDTH-1:0] r, input logic clr, input logic [WIDTH-1:0] q,
                     input logic [WIDTH-1:0] qf, input logic [WIDTH-1:0] ill,
                     input logic [CNT_W-1:0] cnt);
    vec_t v;
    v.en = en; v.mode = mode; v.s = s; v.r = r; v.clr = clr;
    v.q = q; v.qf = qf; v.ill = ill; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    push_exp(8'h00, 8'hFF, 8'h00, 2'd0, "reset_state");
    pop_check();

`ifndef SR_FF_BANK_SYNC_EN
    // SR truth table, invalid pair and its hold
    add(1'b1, 2'b00, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'hF0, 8'h00, 2'd0);
    add(1'b1, 2'b00, 8'h01, 8'h01, 1'b0, 8'h0E, 8'hF0, 8'h01, 2'd1);
    add(1'b1, 2'b00, 8'h00, 8'h00, 1'b0, 8'h0E, 8'hF0, 8'h01, 2'd1);
    add(1'b1, 2'b00, 8'hF0, 8'h0F, 1'b0, 8'hF0, 8'h0F, 8'h01, 2'd1);
    add(1'b1, 2'b00, 8'h00, 8'h00, 1'b1, 8'hF0, 8'h0F, 8'h00, 2'd0);
    // D load, JK toggle twice, set/reset, hold
    add(1'b1, 2'b10, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 2'd0);
    add(1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h00, 8'h00, 2'd0);
    add(1'b1, 2'b01, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'hFF, 8'h00, 2'd0);
    add(1'b1, 2'b01, 8'h0F, 8'hF0, 1'b0, 8'h0F, 8'hF0, 8'h00, 2'd0);
    add(1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 8'h0F, 8'hF0, 8'h00, 2'd0);
    // T mode, R ignored
    add(1'b1, 2'b11, 8'hAA, 8'h00, 1'b0, 8'hA5, 8'h5A, 8'h00, 2'd0);
    add(1'b1, 2'b11, 8'hAA, 8'hFF, 1'b0, 8'h0F, 8'hF0, 8'h00, 2'd0);
    add(1'b1, 2'b11, 8'h00, 8'h00, 1'b0, 8'h0F, 8'hF0, 8'h00, 2'd0);
    // enable hold for 5 edges, then load
    for (int i = 0; i < 5; i++) add(1'b0, 2'b10, 8'h5A, 8'h00, 1'b0, 8'h0F, 8'hF0, 8'h00, 2'd0);
    add(1'b1, 2'b10, 8'h5A, 8'h00, 1'b0, 8'h5A, 8'hA5, 8'h00, 2'd0);
    // S=R=1 outside SR mode is not illegal
    add(1'b1, 2'b10, 8'hFF, 8'hFF, 1'b0, 8'hFF, 8'h00, 8'h00, 2'd0);
    // five consecutive illegal cycles saturate the 2-bit counter
    add(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 2'd1);
    add(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 2'd2);
    add(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 2'd3);
    add(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 2'd3);
    add(1'b1, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 2'd3);
    // disabled forbidden pair is not an event
    add(1'b0, 2'b00, 8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 8'hFF, 2'd3);
    // clear with simultaneous event: event wins
    add(1'b1, 2'b00, 8'h80, 8'h80, 1'b1, 8'h00, 8'h00, 8'h80, 2'd1);
    // clear honoured while disabled
    add(1'b0, 2'b00, 8'h80, 8'h80, 1'b1, 8'h00, 8'h00, 8'h00, 2'd0);
    // JK resolves held 0/0 pairs
    add(1'b1, 2'b01, 8'h00, 8'h00, 1'b0, 8'h00, 8'hFF, 8'h00, 2'd0);
    // set up nonzero state and a flag before the async reset check
    add(1'b1, 2'b00, 8'hFF, 8'h01, 1'b0, 8'hFE, 8'h00, 8'h01, 2'd1);
    for (int i = 0; i < vecs.size(); i++) begin
      apply(vecs[i], $sformatf("vec%0d", i));
    end
`else
    // synchronised path: D load of 8'h3C appears exactly on the third edge
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 8'h00, 8'h00, 1'b0);
      push_exp(8'h00, 8'hFF, 8'h00, 2'd0, "sync_idle");
      @(posedge clk); #1; pop_check();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'b10, 8'h3C, 8'h00, 1'b0);
      if (i < 2) push_exp(8'h00, 8'hFF, 8'h00, 2'd0, $sformatf("sync_early%0d", i));
      else       push_exp(8'h3C, 8'hC3, 8'h00, 2'd0, $sformatf("sync_load%0d", i));
      @(posedge clk); #1; pop_check();
    end
`endif

    // asynchronous reset mid-cycle, no edge needed
    drive(1'b1, 2'b10, 8'hFF, 8'h00, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(8'h00, 8'hFF, 8'h00, 2'd0, "async_reset_immediate");
    pop_check();
    @(posedge clk);
    #1;
    push_exp(8'h00, 8'hFF, 8'h00, 2'd0, "reset_held_over_edge");
    pop_check();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 2'b00, 8'h00, 8'h00, 1'b0);
    @(posedge clk);
    #1;

    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_leftover: %0d entries remain, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sr_ff_bank.md
Name: sr_ff_bank

Overview:
- Parametrised bank of WIDTH clocked bistable cells. It is the edge-triggered, multi-channel successor of the team's level-sensitive SR latch.
- Each channel keeps a true output Q and a separate "false" output QF. A runtime MODE selects SR, JK, D or T behaviour for all channels.
- Tracks forbidden SR inputs (S=R=1) with per-channel sticky flags and a saturating event counter.
- Used as a generic state-storage primitive in lab datapaths and board I/O experiments.

Parameters:
- WIDTH, 8, number of independent channels (1..32).
- CNT_W, 8, width of the illegal-event counter ILL_CNT (2..16).

Ports:
- CLK  input  1  system clock, rising-edge active.
- RST_N  input  1  asynchronous reset, active-low. Deassertion is synchronous to CLK externally.
- EN  input  1  global clock enable. When 0, all state holds.
- MODE  input  2  00=SR, 01=JK (S=J, R=K), 10=D (S=D, R ignored), 11=T (S=T, R ignored).
- S  input  WIDTH  set / J / D / T per channel.
- R  input  WIDTH  reset / K per channel.
- CLR_ILL  input  1  synchronous clear of ILLEGAL and ILL_CNT.
- Q  output  WIDTH  true output per channel.
- QF  output  WIDTH  false output per channel. Not necessarily ~Q; see SR mode.
- ILLEGAL  output  WIDTH  sticky flag per channel: S=R=1 was seen in SR mode.
- ILL_CNT  output  CNT_W  saturating count of cycles with at least one illegal channel.

Behaviour:
- Reset (RST_N=0, asynchronous): Q=0, QF=1, ILLEGAL=0, ILL_CNT=0. This takes effect immediately, mid-cycle, regardless of EN or MODE.
- All state updates happen on the rising CLK edge. Latency is 1 cycle: inputs sampled at edge k appear on the outputs after edge k.
- EN=0: Q, QF, ILLEGAL and ILL_CNT all hold. CLR_ILL is still honoured while EN=0.
- SR mode, per channel:
  - S=0, R=1: Q=0, QF=1.
  - S=1, R=0: Q=1, QF=0.
  - S=1, R=1: Q=0, QF=0 (invalid pair), and the channel's ILLEGAL bit is set.
  - S=0, R=0: Q and QF both hold their current values, including a held invalid 0/0 pair.
- JK mode, per channel, with n = Q:
  - 00 hold, 01 → 0, 10 → 1, 11 → ~n.
  - QF is always updated to ~(new Q).
  - An invalid pair (Q=0, QF=0) with J=K=0 resolves to Q=0, QF=1.
- D mode: Q=S, QF=~S.
- T mode: Q=Q^S, QF=~(Q^S).
- After the first enabled edge in JK, D or T mode, QF=~Q always holds.
- Changing MODE takes effect at the next edge. There is no pipeline and no reset of Q on a mode change.
- Illegal event: an edge with EN=1, MODE=00 and (S&R)!=0.
  - ILLEGAL |= (S&R).
  - ILL_CNT increments by 1 per event cycle, not per channel, and saturates at 2^CNT_W-1 with no wrap.
- CLR_ILL=1 on an edge with no illegal event: ILLEGAL=0, ILL_CNT=0.
- CLR_ILL and an illegal event on the same edge: the new event wins. ILLEGAL = (S&R) of that cycle only, and ILL_CNT=1.
- CLR_ILL does not affect Q or QF.

Optional Feature:
- Macro: SR_FF_BANK_SYNC_EN.
- Defined: S, R and MODE each pass through a 2-flop synchroniser clocked by CLK before use.
  - Synchroniser flops reset to 0 asynchronously, and EN is applied after synchronisation.
  - Input-to-output latency becomes 3 cycles. Illegal detection uses the synchronised values.
- Undefined: inputs are used directly with 1-cycle latency and no extra flops.

Test Plan:
- Reset: WIDTH=8, drive RST_N=0 mid-cycle with S=8'hFF → Q=8'h00, QF=8'hFF, ILLEGAL=0, ILL_CNT=0 immediately, without waiting for an edge.
- SR truth table: MODE=00, EN=1, S=8'h0F, R=8'hF0 → Q=8'h0F, QF=8'hF0. Then S=8'h01, R=8'h01 → Q[0]=0, QF[0]=0, ILLEGAL=8'h01, ILL_CNT=1. Then S=R=0 → Q[0]=0, QF[0]=0 held.
- JK/T toggle: MODE=01, S=R=8'hFF from Q=8'h00 → Q=8'hFF, QF=8'h00 after one edge, 8'h00/8'hFF after the next. MODE=11 with S=8'hAA gives Q=Q^8'hAA.
- Enable hold: EN=0, MODE=10, S=8'h5A for 5 edges → Q and QF unchanged. Raising EN gives Q=8'h5A, QF=8'hA5 on the next edge.
- Counter saturation/clear: CNT_W=2, 5 consecutive illegal cycles → ILL_CNT=3, held. CLR_ILL on an edge with an illegal event on S=R=8'h80 → ILLEGAL=8'h80, ILL_CNT=1. CLR_ILL alone → 0, 0.
- SYNC_EN build: MODE=10, step S from 8'h00 to 8'h3C → Q=8'h3C exactly 3 edges later, not earlier.
